// File: rtl/stack_sequencer.sv
// stack_sequencer
//   Multi-cycle PUSH/POP engine. Walks an 8-bit register mask and moves each
//   selected register between the register file and data memory using a
//   full-descending stack of 32-bit words. It finishes with a one-cycle SP
//   write and holds busy high while it is active so that the core stalls.
//
// Ports
//   clk, reset                 clock, async active-high reset
//   start, op_pop, reg_mask,   request (sampled in IDLE only)
//   sp_in
//   rd_addr / rd_data          register-file read port (PUSH)
//   reg_wr_en/addr/data        register-file write strobe (POP)
//   mem_req/we/addr/wdata      memory request, held until mem_ack
//   mem_ack / mem_rdata        memory handshake / load data
//   wr_sp / wr_sp_data         final SP update strobe
//   busy, done, err            status
module stack_sequencer #(
  parameter logic [31:0] SP_LIMIT = 32'h0000_1000,
  parameter logic [31:0] SP_BASE  = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op_pop,
  input  logic [7:0]  reg_mask,
  input  logic [31:0] sp_in,
  output logic [2:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        reg_wr_en,
  output logic [2:0]  reg_wr_addr,
  output logic [31:0] reg_wr_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wr_sp,
  output logic [31:0] wr_sp_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_SEL   = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  logic [2:0]  state;
  logic        op_q;
  logic [7:0]  mask_q;
  logic [31:0] ptr_q;    // starts at sp_in; walks to the final SP
  logic [3:0]  n_q;
  logic        err_q;
  logic        skip_q;   // finish without SP write (error or empty mask)
  logic [2:0]  cur_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  function automatic logic [2:0] hi_idx(input logic [7:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (m[i]) r = i[2:0];
    return r;
  endfunction

  function automatic logic [2:0] lo_idx(input logic [7:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) if (m[i]) r = i[2:0];
    return r;
  endfunction

  function automatic logic [3:0] popcnt(input logic [7:0] m);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, m[i]};
    return c;
  endfunction

  // PUSH drains from the top register down, POP from the bottom up, so a
  // POP of the same mask restores what a PUSH saved.
  logic [2:0] sel_idx;
  assign sel_idx = op_q ? lo_idx(mask_q) : hi_idx(mask_q);

  logic [7:0] mask_left;
  assign mask_left = mask_q & ~(8'b0000_0001 << cur_q);

  // 33-bit arithmetic so that an SP wrap past 0 or 2^32 counts as an error.
  logic [32:0] sp_w, four_n, sp_dn, sp_up;
  logic        chk_bad;
  assign sp_w    = {1'b0, ptr_q};
  assign four_n  = {27'b0, n_q, 2'b00};
  assign sp_dn   = sp_w - four_n;
  assign sp_up   = sp_w + four_n;
  assign chk_bad = (ptr_q[1:0] != 2'b00) ||
                   (!op_q && (sp_dn[32] || sp_dn < {1'b0, SP_LIMIT})) ||
                   ( op_q && (sp_up > {1'b0, SP_BASE}));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      op_q    <= 1'b0;
      mask_q  <= '0;
      ptr_q   <= '0;
      n_q     <= '0;
      err_q   <= 1'b0;
      skip_q  <= 1'b0;
      cur_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          op_q   <= op_pop;
          mask_q <= reg_mask;
          ptr_q  <= sp_in;
          n_q    <= popcnt(reg_mask);
          err_q  <= 1'b0;
          skip_q <= 1'b0;
          state  <= S_CHECK;
        end
        S_CHECK: begin
          if (chk_bad) begin
            err_q  <= 1'b1;
            skip_q <= 1'b1;
            state  <= S_FIN;
          end else if (mask_q == 8'h00) begin
            skip_q <= 1'b1;
            state  <= S_FIN;
          end else begin
            state  <= S_SEL;
          end
        end
        S_SEL: begin
          cur_q <= sel_idx;
          if (!op_q) begin
            // full-descending: pre-decrement, then store
            ptr_q   <= ptr_q - 32'd4;
            addr_q  <= ptr_q - 32'd4;
            wdata_q <= rd_data;
          end else begin
            addr_q  <= ptr_q;
            ptr_q   <= ptr_q + 32'd4;
          end
          state <= S_MEM;
        end
        S_MEM: if (mem_ack) begin
          mask_q <= mask_left;
          if (op_q) begin
            rdata_q <= mem_rdata;
            state   <= S_WB;
          end else begin
            state   <= (mask_left == 8'h00) ? S_FIN : S_SEL;
          end
        end
        S_WB:    state <= (mask_q == 8'h00) ? S_FIN : S_SEL;
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so that an async reset drops them at once.
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_FIN);
  assign err         = done & err_q;
  assign wr_sp       = done & ~skip_q;
  assign wr_sp_data  = wr_sp ? ptr_q : 32'h0;
  assign mem_req     = (state == S_MEM);
  assign mem_we      = mem_req & ~op_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign reg_wr_en   = (state == S_WB);
  assign reg_wr_addr = cur_q;
  assign reg_wr_data = rdata_q;
  assign rd_addr     = (state == S_SEL) ? sel_idx : 3'd0;

endmodule

// File: tb/tb_stack_sequencer.sv
module tb_stack_sequencer;
  localparam logic [31:0] SP_LIMIT = 32'h0000_1000;
  localparam logic [31:0] SP_BASE  = 32'h0000_2000;

  logic clk = 1'b0;
  logic reset;
  logic start, op_pop;
  logic [7:0] reg_mask;
  logic [31:0] sp_in;
  logic [2:0] rd_addr;
  logic [31:0] rd_data;
  logic reg_wr_en;
  logic [2:0] reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic mem_ack;
  logic [31:0] mem_rdata;
  logic wr_sp;
  logic [31:0] wr_sp_data;
  logic busy, done, err;

  always #5 clk = ~clk;

  stack_sequencer #(.SP_LIMIT(SP_LIMIT), .SP_BASE(SP_BASE)) dut (
    .clk(clk), .reset(reset), .start(start), .op_pop(op_pop), .reg_mask(reg_mask),
    .sp_in(sp_in), .rd_addr(rd_addr), .rd_data(rd_data), .reg_wr_en(reg_wr_en),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .wr_sp(wr_sp), .wr_sp_data(wr_sp_data), .busy(busy),
    .done(done), .err(err));

  // register file and memory owned by the bench
  logic [31:0] regs [8];
  logic [31:0] mem [logic [31:0]];
  assign rd_data = regs[rd_addr];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  int errors = 0, checks = 0;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // observation state
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ack_dly = 0, wcnt = 0, req_len = 0, unstable = 0;
  bit noise = 0;
  logic prev_req = 0, prev_we = 0;
  logic [31:0] prev_addr = 0, prev_wdata = 0;
  logic [31:0] o_addr[$], o_data[$], o_rdat[$];
  bit o_we[$];
  int o_len[$];
  logic [2:0] o_radr[$];
  int o_wrsp = 0, o_done = 0, o_err = 0;
  logic [31:0] o_wrsp_data = 0;

  always @(negedge clk) begin
    if (mem_req) begin
      if (prev_req && (mem_addr !== prev_addr || mem_wdata !== prev_wdata || mem_we !== prev_we))
        unstable++;
      req_len++;
      mem_ack = (wcnt >= ack_dly);
      wcnt++;
      mem_rdata = mem_we ? 32'h0 : mem_rd(mem_addr);
      if (mem_ack) begin
        o_addr.push_back(mem_addr);
        o_data.push_back(mem_we ? mem_wdata : mem_rdata);
        o_we.push_back(mem_we);
        o_len.push_back(req_len);
        if (mem_we) mem[mem_addr] = mem_wdata;
        req_len = 0;
      end
    end else begin
      // stray acks outside MEM must be ignored by the DUT
      mem_ack = noise ? ($urandom_range(0, 1) == 1) : 1'b0;
      wcnt = 0;
      req_len = 0;
    end
    prev_req = mem_req && !mem_ack;
    prev_addr = mem_addr; prev_wdata = mem_wdata; prev_we = mem_we;
    if (reg_wr_en) begin
      o_radr.push_back(reg_wr_addr);
      o_rdat.push_back(reg_wr_data);
      regs[reg_wr_addr] = reg_wr_data;
    end
    if (wr_sp) begin o_wrsp++; o_wrsp_data = wr_sp_data; end
    if (done) o_done++;
    if (err) o_err++;
  end

  task automatic clear_obs();
    o_addr.delete(); o_data.delete(); o_we.delete(); o_len.delete();
    o_radr.delete(); o_rdat.delete();
    o_wrsp = 0; o_done = 0; o_err = 0; unstable = 0;
  endtask

  // Runs one request and checks it against a reference computed from the
  // stack rules; returns the observed latency for table checks.
  task automatic run_op(input bit op, input logic [7:0] mask, input logic [31:0] sp,
                        input int dly, input bit poke, output int lat);
    int n, guard, st;
    longint lsp;
    bit m_err, m_wrsp;
    logic [31:0] m_sp;
    int m_lat, j;
    logic [31:0] e_addr[$], e_data[$];
    logic [2:0] e_reg[$];
    n = $countones(mask);
    lsp = longint'(sp);
    m_err = (sp[1:0] != 2'b00) || (!op && lsp - 4*n < longint'(SP_LIMIT)) ||
            (op && lsp + 4*n > longint'(SP_BASE));
    m_wrsp = !m_err && (mask != 8'h00);
    m_sp = op ? sp + 32'(4*n) : sp - 32'(4*n);
    m_lat = m_wrsp ? 2 + n * ((op ? 3 : 2) + dly) : 2;
    if (m_wrsp) begin
      j = 0;
      if (!op) begin
        for (int k = 7; k >= 0; k--) if (mask[k]) begin
          e_addr.push_back(sp - 32'(4*(j+1))); e_data.push_back(regs[k]);
          e_reg.push_back(3'(k)); j++;
        end
      end else begin
        for (int k = 0; k < 8; k++) if (mask[k]) begin
          e_addr.push_back(sp + 32'(4*j)); e_data.push_back(mem_rd(sp + 32'(4*j)));
          e_reg.push_back(3'(k)); j++;
        end
      end
    end
    clear_obs();
    ack_dly = dly;
    @(negedge clk); #1;
    start = 1; op_pop = op; reg_mask = mask; sp_in = sp; st = cyc;
    @(negedge clk); #1;
    start = 0;
    guard = 0;
    while (!done && guard < 400) begin
      if (poke && guard == 3) begin
        start = 1; op_pop = ~op; reg_mask = 8'hFF; sp_in = 32'h1800;
      end else start = 0;
      @(negedge clk); #1;
      guard++;
    end
    start = 0;
    chk("done_seen", done, 1'b1);
    lat = cyc - st;
    chk("latency", lat, m_lat);
    @(negedge clk); #1;
    chk("busy_after", busy, 1'b0);
    chk("done_count", o_done, 1);
    chk("err", o_err, m_err);
    chk("wr_sp_count", o_wrsp, m_wrsp);
    if (m_wrsp) chk("wr_sp_data", o_wrsp_data, m_sp);
    chk("n_access", o_addr.size(), e_addr.size());
    for (int i = 0; i < e_addr.size() && i < o_addr.size(); i++) begin
      chk("mem_addr", o_addr[i], e_addr[i]);
      chk("mem_data", o_data[i], e_data[i]);
      chk("mem_we", o_we[i], !op);
      chk("req_cycles", o_len[i], dly + 1);
    end
    chk("n_regwr", o_radr.size(), op ? e_reg.size() : 0);
    if (op) for (int i = 0; i < e_reg.size() && i < o_radr.size(); i++) begin
      chk("reg_wr_addr", o_radr[i], e_reg[i]);
      chk("reg_wr_data", o_rdat[i], e_data[i]);
    end
    chk("req_stable", unstable, 0);
  endtask

  typedef struct {
    bit op; logic [7:0] mask; logic [31:0] sp; int dly; bit poke;
    bit exp_err; int exp_wrsp; logic [31:0] exp_sp; int exp_lat;
  } vec_t;

  vec_t tv[8];
  int lat, guard;

  initial begin
    tv[0] = '{0, 8'h23, 32'h2000, 0, 0, 0, 1, 32'h1FF4, 8};
    tv[1] = '{1, 8'h23, 32'h1FF4, 0, 0, 0, 1, 32'h2000, 11};
    tv[2] = '{0, 8'h23, 32'h2002, 0, 0, 1, 0, 32'h0, 2};
    tv[3] = '{0, 8'h00, 32'h2000, 0, 0, 0, 0, 32'h0, 2};
    tv[4] = '{0, 8'h07, 32'h1008, 0, 0, 1, 0, 32'h0, 2};
    tv[5] = '{1, 8'h01, 32'h2000, 0, 0, 1, 0, 32'h0, 2};
    tv[6] = '{0, 8'h07, 32'h100C, 0, 0, 0, 1, 32'h1000, 8};
    tv[7] = '{0, 8'h23, 32'h2000, 3, 1, 0, 1, 32'h1FF4, 17};

    for (int i = 0; i < 8; i++) regs[i] = 32'h100 + i;
    regs[0] = 32'hA0; regs[1] = 32'hA1; regs[5] = 32'hA5;
    mem_ack = 0; mem_rdata = 0;
    start = 0; op_pop = 0; reg_mask = 0; sp_in = 0;
    reset = 1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done_err_wrsp", {done, err, wr_sp}, 3'b000);
    chk("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata}, 66'h0);
    chk("rst_reg_wr", {reg_wr_en, reg_wr_addr, reg_wr_data, wr_sp_data}, 68'h0);
    repeat (2) @(negedge clk);
    reset = 0;

    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin regs[0] = 32'h0; regs[1] = 32'h0; regs[5] = 32'h0; end
      run_op(tv[i].op, tv[i].mask, tv[i].sp, tv[i].dly, tv[i].poke, lat);
      chk($sformatf("tv%0d_err", i), o_err, tv[i].exp_err);
      chk($sformatf("tv%0d_wrsp", i), o_wrsp, tv[i].exp_wrsp);
      if (tv[i].exp_wrsp != 0) chk($sformatf("tv%0d_sp", i), o_wrsp_data, tv[i].exp_sp);
      chk($sformatf("tv%0d_lat", i), lat, tv[i].exp_lat);
      chk($sformatf("tv%0d_nreq", i), o_addr.size(), tv[i].exp_wrsp != 0 ? $countones(tv[i].mask) : 0);
      if (i == 0) begin
        chk("t1_mem_1FFC", mem[32'h1FFC], 32'hA5);
        chk("t1_mem_1FF8", mem[32'h1FF8], 32'hA1);
        chk("t1_mem_1FF4", mem[32'h1FF4], 32'hA0);
      end
      if (i == 1) chk("t2_regs", {regs[0], regs[1], regs[5]}, {32'hA0, 32'hA1, 32'hA5});
    end

    // reset during the second PUSH access
    clear_obs();
    ack_dly = 3;
    @(negedge clk); #1;
    start = 1; op_pop = 0; reg_mask = 8'h23; sp_in = 32'h2000; regs[5] = 32'h55;
    @(negedge clk); #1;
    start = 0;
    guard = 0;
    while (!(o_addr.size() == 1 && mem_req && mem_addr == 32'h1FF8) && guard < 100) begin
      @(negedge clk); #1; guard++;
    end
    chk("rst_reached_2nd_mem", guard < 100, 1'b1);
    #2 reset = 1;
    #1;
    chk("rst_mid_mem_req", mem_req, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mid_no_done", o_done, 0);
    chk("rst_mid_no_wrsp", o_wrsp, 0);
    chk("rst_mid_partial", mem[32'h1FFC], 32'h55);
    reset = 0;
    run_op(0, 8'h23, 32'h2000, 0, 0, lat);
    chk("post_rst_lat", lat, 8);

    // randomized requests against the reference rules
    noise = 1;
    for (int i = 0; i < 8; i++) regs[i] = $urandom;
    for (int it = 0; it < 40; it++) begin
      bit op;
      logic [7:0] mask;
      logic [31:0] sp;
      op = ($urandom_range(0, 1) == 1);
      mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      sp = SP_LIMIT + 32'(4 * $urandom_range(0, 32'h400));
      if ($urandom_range(0, 9) == 0) sp = sp | 32'($urandom_range(1, 3));
      run_op(op, mask, sp, $urandom_range(0, 2), $urandom_range(0, 1) == 1, lat);
    end
    noise = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end
endmodule
